// File: rtl/akarin_lsu_pkg.sv
// Shared encodings for the load/store unit: RV32 funct3 size codes, error codes, FSM states.
package akarin_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_ILLEGAL  = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } lsu_err_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_ERR  = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/memory_bus.sv
// Word-addressed memory bus with byte strobes and a ready handshake from the memory side.
interface memory_bus;
   logic [31:2] addr;
   logic [31:0] dataD;
   logic [31:0] dataQ;
   logic        read;
   logic        write;
   logic        ready;
   logic [3:0]  byteSel;

   modport master (output addr, dataD, read, write, byteSel, input dataQ, ready);
   modport slave  (input addr, dataD, read, write, byteSel, output dataQ, ready);
endinterface

// File: rtl/lsu_align.sv
// Combinational size/alignment logic: byte strobes, store lane replication, load extraction/extension.
module lsu_align
   import akarin_lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] dataq,
   output logic [3:0]  byte_sel,
   output logic [31:0] data_d,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        illegal
);

   logic [31:0] shifted;

   assign shifted = dataq >> {off, 3'b000};

   always_comb begin
      illegal = we ? (funct3 > F3_SW)
                   : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
      // funct3[1:0] is the access size for both the signed and unsigned load codes
      misaligned = (funct3[1:0] == 2'd1 && off[0]) || (funct3[1:0] == 2'd2 && off != 2'd0);
      case (funct3[1:0])
         2'd0: begin
            byte_sel = 4'b0001 << off;
            data_d   = {4{wdata[7:0]}};
         end
         2'd1: begin
            byte_sel = 4'b0011 << off;
            data_d   = {2{wdata[15:0]}};
         end
         default: begin
            byte_sel = 4'b1111;
            data_d   = wdata;
         end
      endcase
      case (funct3)
         F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   rdata = shifted;
         F3_LBU:  rdata = {24'd0, shifted[7:0]};
         F3_LHU:  rdata = {16'd0, shifted[15:0]};
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// RV32 load/store unit driving memory_bus; one request in flight, 2+ cycles accept-to-response.
// req_ready only in IDLE (including the response cycle); bus wait bounded by TIMEOUT (0 = unbounded).
module mem_access_unit
   import akarin_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   memory_bus.master   bus
);

   localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit             TO_EN    = (TIMEOUT != 0);

   lsu_state_t    state_q, state_d;
   lsu_err_t      err_q, err_d, resp_err_q, resp_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [31:2]   addr_q, addr_d;
   logic          read_q, read_d, write_q, write_d;
   logic [31:0]   data_d_q, data_d_d;
   logic [3:0]    byte_sel_q, byte_sel_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;

   logic          al_we;
   logic [2:0]    al_f3;
   logic [1:0]    al_off;
   logic [3:0]    al_byte_sel;
   logic [31:0]   al_data_d, al_rdata;
   logic          al_misaligned, al_illegal;

   // One aligner: decodes the incoming request in IDLE, extracts load data from the held access in BUS
   assign al_we  = (state_q == ST_IDLE) ? req_we        : we_q;
   assign al_f3  = (state_q == ST_IDLE) ? req_funct3    : f3_q;
   assign al_off = (state_q == ST_IDLE) ? req_addr[1:0] : off_q;

   lsu_align u_align (
      .we         (al_we),
      .funct3     (al_f3),
      .off        (al_off),
      .wdata      (req_wdata),
      .dataq      (bus.dataQ),
      .byte_sel   (al_byte_sel),
      .data_d     (al_data_d),
      .rdata      (al_rdata),
      .misaligned (al_misaligned),
      .illegal    (al_illegal)
   );

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      f3_d         = f3_q;
      off_d        = off_q;
      addr_d       = addr_q;
      read_d       = read_q;
      write_d      = write_q;
      data_d_d     = data_d_q;
      byte_sel_d   = byte_sel_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d  = req_we;
               f3_d  = req_funct3;
               off_d = req_addr[1:0];
               cnt_d = '0;
               if (al_illegal) begin
                  state_d = ST_ERR;
                  err_d   = ERR_ILLEGAL;
               end else if (al_misaligned) begin
                  state_d = ST_ERR;
                  err_d   = ERR_MISALIGN;
               end else begin
                  state_d    = ST_BUS;
                  addr_d     = req_addr[31:2];
                  read_d     = !req_we;
                  write_d    = req_we;
                  data_d_d   = al_data_d;
                  byte_sel_d = al_byte_sel;
               end
            end
         end
         ST_BUS: begin
            if (bus.ready) begin
               state_d      = ST_IDLE;
               read_d       = 1'b0;
               write_d      = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = ERR_OK;
               resp_rdata_d = we_q ? 32'd0 : al_rdata;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               state_d      = ST_IDLE;
               read_d       = 1'b0;
               write_d      = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = ERR_TIMEOUT;
               resp_rdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ERR: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
            resp_rdata_d = 32'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         err_q        <= ERR_OK;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         off_q        <= 2'd0;
         addr_q       <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         data_d_q     <= 32'd0;
         byte_sel_q   <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= ERR_OK;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         addr_q       <= addr_d;
         read_q       <= read_d;
         write_q      <= write_d;
         data_d_q     <= data_d_d;
         byte_sel_q   <= byte_sel_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign bus.addr    = addr_q;
   assign bus.dataD   = data_d_q;
   assign bus.read    = read_q;
   assign bus.write   = write_q;
   assign bus.byteSel = byte_sel_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4; the bench plays the memory side of the bus.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;

   int checks   = 0;
   int failures = 0;

   memory_bus bus_if ();

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .bus        (bus_if.master)
   );

   always #5 clk = ~clk;

   // Issues one request from IDLE and plays memory: ready is raised in strobe cycle delay+1 (never if delay<0).
   // lat counts cycles from the accepting edge to the resp_valid cycle.
   task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] dq, input int delay,
                             output logic got, output logic [31:0] rd, output logic [1:0] err,
                             output int strobes, output int lat, output logic [31:2] s_addr,
                             output logic [3:0] s_bsel, output logic [31:0] s_dd);
      got = 1'b0; rd = 32'd0; err = 2'd0; strobes = 0; lat = 0;
      s_addr = '0; s_bsel = 4'd0; s_dd = 32'd0;
      bus_if.dataQ = dq;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!got && lat < 40) begin
         if (resp_valid) begin
            got = 1'b1; rd = resp_rdata; err = resp_err;
         end else begin
            if (bus_if.read || bus_if.write) begin
               strobes++;
               if (strobes == 1) begin
                  s_addr = bus_if.addr; s_bsel = bus_if.byteSel; s_dd = bus_if.dataD;
               end
               if (delay >= 0 && strobes == delay + 1) bus_if.ready = 1'b1;
            end
            @(posedge clk); #1;
            bus_if.ready = 1'b0;
            lat++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; bus_if.ready = 1'b0; bus_if.dataQ = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus_if.read !== 1'b0 || bus_if.write !== 1'b0) begin failures++; $display("FAIL reset_strobes: got r=%b w=%b exp 0 0", bus_if.read, bus_if.write); end
      checks++; if (bus_if.addr !== 30'd0 || bus_if.dataD !== 32'd0 || bus_if.byteSel !== 4'd0) begin failures++; $display("FAIL reset_bus: got addr=%h dd=%h bs=%b exp 0", bus_if.addr, bus_if.dataD, bus_if.byteSel); end
      checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 2'd0) begin failures++; $display("FAIL reset_resp: got v=%b rd=%h err=%0d exp 0", resp_valid, resp_rdata, resp_err); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_byte();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h0000_1003; req_wdata = 32'h0000_00AB;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (bus_if.write !== 1'b1 || bus_if.read !== 1'b0) begin failures++; $display("FAIL sb_strobe: got w=%b r=%b exp 1 0", bus_if.write, bus_if.read); end
      checks++; if (bus_if.addr !== 30'h400) begin failures++; $display("FAIL sb_addr: got %h exp 400", bus_if.addr); end
      checks++; if (bus_if.byteSel !== 4'b1000) begin failures++; $display("FAIL sb_bytesel: got %b exp 1000", bus_if.byteSel); end
      checks++; if (bus_if.dataD !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_datad: got %h exp ababab ab", bus_if.dataD); end
      bus_if.ready = 1'b1;
      @(posedge clk); #1;
      bus_if.ready = 1'b0;
      checks++; if (bus_if.write !== 1'b0) begin failures++; $display("FAIL sb_write_drop: got %b exp 0", bus_if.write); end
      checks++; if (resp_valid !== 1'b1 || resp_err !== 2'd0 || resp_rdata !== 32'd0) begin failures++; $display("FAIL sb_resp: got v=%b err=%0d rd=%h exp 1 0 0", resp_valid, resp_err, resp_rdata); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sb_resp_pulse: got %b exp 0", resp_valid); end
   endtask

   task automatic test_loads();
      logic got; logic [31:0] rd; logic [1:0] err; int st; int lat;
      logic [31:2] sa; logic [3:0] sb; logic [31:0] sd;
      run_access(1'b0, 3'd0, 32'h0000_2001, 32'd0, 32'h1234_8076, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || rd !== 32'hFFFF_FF80 || err !== 2'd0) begin failures++; $display("FAIL lb: got v=%b rd=%h err=%0d exp 1 ffffff80 0", got, rd, err); end
      checks++; if (sb !== 4'b0010 || sa !== 30'h800 || st !== 1 || lat !== 2) begin failures++; $display("FAIL lb_bus: got bs=%b addr=%h strobes=%0d lat=%0d exp 0010 800 1 2", sb, sa, st, lat); end
      run_access(1'b0, 3'd4, 32'h0000_2001, 32'd0, 32'h1234_8076, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || rd !== 32'h0000_0080 || err !== 2'd0) begin failures++; $display("FAIL lbu: got v=%b rd=%h err=%0d exp 1 00000080 0", got, rd, err); end
      run_access(1'b0, 3'd1, 32'h0000_2002, 32'd0, 32'h1234_8076, 1, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || rd !== 32'h0000_1234 || sb !== 4'b1100 || lat !== 3) begin failures++; $display("FAIL lh: got v=%b rd=%h bs=%b lat=%0d exp 1 00001234 1100 3", got, rd, sb, lat); end
      run_access(1'b0, 3'd1, 32'h0000_2002, 32'd0, 32'hFEDC_0000, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (rd !== 32'hFFFF_FEDC) begin failures++; $display("FAIL lh_neg: got %h exp fffffedc", rd); end
      run_access(1'b0, 3'd5, 32'h0000_2002, 32'd0, 32'hFEDC_0000, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (rd !== 32'h0000_FEDC) begin failures++; $display("FAIL lhu: got %h exp 0000fedc", rd); end
      run_access(1'b0, 3'd2, 32'h0000_2000, 32'd0, 32'h89AB_CDEF, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (rd !== 32'h89AB_CDEF || sb !== 4'b1111) begin failures++; $display("FAIL lw: got rd=%h bs=%b exp 89abcdef 1111", rd, sb); end
      run_access(1'b1, 3'd1, 32'h0000_2002, 32'h1234_5678, 32'hFFFF_FFFF, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (sd !== 32'h5678_5678 || sb !== 4'b1100 || rd !== 32'd0) begin failures++; $display("FAIL sh: got dd=%h bs=%b rd=%h exp 56785678 1100 0", sd, sb, rd); end
   endtask

   task automatic test_errors();
      logic got; logic [31:0] rd; logic [1:0] err; int st; int lat;
      logic [31:2] sa; logic [3:0] sb; logic [31:0] sd;
      run_access(1'b0, 3'd2, 32'h0000_3002, 32'd0, 32'h5555_5555, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || err !== 2'd1 || st !== 0 || lat !== 2 || rd !== 32'd0) begin failures++; $display("FAIL lw_misalign: got v=%b err=%0d strobes=%0d lat=%0d rd=%h exp 1 1 0 2 0", got, err, st, lat, rd); end
      run_access(1'b1, 3'd3, 32'h0000_3000, 32'h1111_1111, 32'd0, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (err !== 2'd2 || st !== 0 || lat !== 2) begin failures++; $display("FAIL st_illegal: got err=%0d strobes=%0d lat=%0d exp 2 0 2", err, st, lat); end
      run_access(1'b0, 3'd7, 32'h0000_3001, 32'd0, 32'd0, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (err !== 2'd2) begin failures++; $display("FAIL illegal_priority: got err=%0d exp 2", err); end
      run_access(1'b0, 3'd3, 32'h0000_3000, 32'd0, 32'd0, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (err !== 2'd2 || st !== 0) begin failures++; $display("FAIL ld_illegal3: got err=%0d strobes=%0d exp 2 0", err, st); end
      run_access(1'b0, 3'd5, 32'h0000_3001, 32'd0, 32'd0, 0, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (err !== 2'd1 || st !== 0) begin failures++; $display("FAIL lhu_misalign: got err=%0d strobes=%0d exp 1 0", err, st); end
   endtask

   task automatic test_timeout();
      logic got; logic [31:0] rd; logic [1:0] err; int st; int lat;
      logic [31:2] sa; logic [3:0] sb; logic [31:0] sd;
      run_access(1'b0, 3'd2, 32'h0000_4000, 32'd0, 32'hCAFE_F00D, -1, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || err !== 2'd3 || st !== 4 || rd !== 32'd0 || lat !== 5) begin failures++; $display("FAIL timeout: got v=%b err=%0d strobes=%0d rd=%h lat=%0d exp 1 3 4 0 5", got, err, st, rd, lat); end
      run_access(1'b0, 3'd2, 32'h0000_4000, 32'd0, 32'hCAFE_F00D, 3, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || err !== 2'd0 || st !== 4 || rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL ready_at_limit: got v=%b err=%0d strobes=%0d rd=%h exp 1 0 4 cafef00d", got, err, st, rd); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0000_4000; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (bus_if.dataD !== 32'hDEAD_BEEF || bus_if.byteSel !== 4'b1111 || bus_if.write !== 1'b1) begin failures++; $display("FAIL b2b_first: got dd=%h bs=%b w=%b exp deadbeef 1111 1", bus_if.dataD, bus_if.byteSel, bus_if.write); end
      bus_if.ready = 1'b1;
      @(posedge clk); #1;
      bus_if.ready = 1'b0;
      checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_resp_cycle: got v=%b rdy=%b exp 1 1", resp_valid, req_ready); end
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd4; req_addr = 32'h0000_4005; req_wdata = 32'd0;
      bus_if.dataQ = 32'h0000_AA00;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (bus_if.read !== 1'b1 || bus_if.byteSel !== 4'b0010 || bus_if.addr !== 30'h1001 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_second: got r=%b bs=%b addr=%h v=%b exp 1 0010 1001 0", bus_if.read, bus_if.byteSel, bus_if.addr, resp_valid); end
      bus_if.ready = 1'b1;
      @(posedge clk); #1;
      bus_if.ready = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_00AA || resp_err !== 2'd0) begin failures++; $display("FAIL b2b_second_resp: got v=%b rd=%h err=%0d exp 1 000000aa 0", resp_valid, resp_rdata, resp_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int seen;
      logic got; logic [31:0] rd; logic [1:0] err; int st; int lat;
      logic [31:2] sa; logic [3:0] sb; logic [31:0] sd;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_5000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (bus_if.read !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got r=%b exp 1", bus_if.read); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus_if.read !== 1'b0 || bus_if.write !== 1'b0) begin failures++; $display("FAIL rst_mid_async: got r=%b w=%b exp 0 0", bus_if.read, bus_if.write); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 2'd0 || bus_if.addr !== 30'd0 || bus_if.dataD !== 32'd0 || bus_if.byteSel !== 4'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_values: got v=%b rd=%h err=%0d addr=%h dd=%h bs=%b rdy=%b exp 0 0 0 0 0 0 1", resp_valid, resp_rdata, resp_err, bus_if.addr, bus_if.dataD, bus_if.byteSel, req_ready); end
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid || bus_if.read || bus_if.write) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d active cycles exp 0", seen); end
      run_access(1'b0, 3'd2, 32'h0000_5004, 32'd0, 32'h1357_9BDF, 1, got, rd, err, st, lat, sa, sb, sd);
      checks++; if (got !== 1'b1 || rd !== 32'h1357_9BDF || err !== 2'd0 || lat !== 3) begin failures++; $display("FAIL rst_recover: got v=%b rd=%h err=%0d lat=%0d exp 1 13579bdf 0 3", got, rd, err, lat); end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_loads();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
